regfile_param: RTL

Parametrised successor to the single-cycle processor's register file: two asynchronous read ports and one synchronous write port, with configurable data width and address width. It adds a hardware clear sequencer that zeroes every entry after reset, with a `busy` flag while the clear runs. Entry 0 is optionally hardwired to zero, and write-to-read forwarding is selectable at compile time. It sits between the decode stage (`rs`/`rt`/`rd`) and the ALU/writeback mux (`Data_In`).

---
 rtl/regfile_param.sv | 105 ++++++++++
 1 files changed

// File: rtl/regfile_param.sv
// Two-read / one-write register file with a post-reset clear sweep and optional hardwired entry 0.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module regfile_param #(
    parameter int WIDTH   = 32,
    parameter int ADDR_W  = 5,
    parameter int ZERO_R0 = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] rd,
    input  logic [WIDTH-1:0]  Data_In,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [WIDTH-1:0]  Rdata1,
    output logic [WIDTH-1:0]  Rdata2,
    output logic              busy
);

    // state  | meaning
    // CLEAR  | sweeping zeros through every entry, user writes ignored, reads return 0
    // READY  | normal register-file operation
    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    localparam int DEPTH = 1 << ADDR_W;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              user_wr;
    logic              rd_is_r0;
    logic              byp_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == S_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                state_d = S_READY;
            end
        end
    end

    always_comb begin
        busy     = (state_q == S_CLEAR);
        rd_is_r0 = (ZERO_R0 != 0) && (rd == '0);
        byp_ok   = !busy && RegWrite && !rd_is_r0;
        user_wr  = !rst && byp_ok;
        wr_en    = 1'b0;
        wr_addr  = rd;
        wr_data  = Data_In;
        if (busy) begin
            // The sweep owns the single write port; a user write here is simply lost.
            wr_en   = !rst;
            wr_addr = clr_cnt_q;
            wr_data = '0;
        end else if (user_wr) begin
            wr_en = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        Rdata1 = mem_q[rs];
        Rdata2 = mem_q[rt];
`ifdef REGFILE_BYPASS_EN
        if (byp_ok && (rd == rs)) begin
            Rdata1 = Data_In;
        end
        if (byp_ok && (rd == rt)) begin
            Rdata2 = Data_In;
        end
`endif
        if (busy || ((ZERO_R0 != 0) && (rs == '0))) begin
            Rdata1 = '0;
        end
        if (busy || ((ZERO_R0 != 0) && (rt == '0))) begin
            Rdata2 = '0;
        end
    end

endmodule
